mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide ports (name  direction  width  meaning):
- clk  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_done or cpu_err
- cpu_we  in  1  CPU write enable (1 = write, 0 = read)
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  CPU read data, registered
- cpu_done  out  1  one-cycle completion pulse for CPU
- cpu_err  out  1  one-cycle timeout pulse for CPU
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_done, dma_err  same directions and widths as the cpu_* ports, for the DMA requester
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion, one cycle
- busy  out  1  arbiter not in IDLE
- owner  out  1  current/last grantee (0 = CPU, 1 = DMA)

REQ-002 SHALL use one clock; reset SHALL be synchronous and active-high, named clk and reset.

Function
REQ-003 SHALL implement the FSM IDLE -> ACCESS -> DONE -> IDLE.
REQ-004 IDLE: if any req=1, SHALL select a winner, latch that requester's we/addr/wdata into internal registers, update owner, and enter ACCESS on the next edge; otherwise SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin:
- single requester: that requester wins
- both requesting: the grantee is the inverse of last_owner
- last_owner resets to 1, so the CPU wins the first tie
REQ-006 ACCESS: mem_en=1; mem_we/mem_addr/mem_wdata SHALL be driven from the latched registers, stable for the whole state.
REQ-007 ACCESS SHALL run a 4-bit wait counter, cleared on entry and incremented each cycle mem_ready=0.
REQ-008 ACCESS with mem_ready=1: on a read, SHALL capture mem_rdata into the owner's rdata register; SHALL then enter DONE.
REQ-009 ACCESS with the counter at 15 and mem_ready=0 SHALL enter DONE with a timeout flag set; mem_ready=1 in that same cycle SHALL take precedence (normal completion).
REQ-010 DONE SHALL last exactly one cycle:
- mem_en=0
- owner's done=1 (or err=1 if timed out, never both)
- last_owner <= owner
- next state IDLE
REQ-011 Latency: req sampled in IDLE at cycle N gives mem_en=1 at N+1; mem_ready at cycle M gives done at M+1 and IDLE at M+2; back-to-back service SHALL therefore have one IDLE cycle between accesses.
REQ-012 Deasserting req during ACCESS SHALL NOT abort the access; done/err still pulses.
REQ-013 Changing a requester's addr/wdata/we after grant SHALL NOT affect the access in flight.
REQ-014 rdata registers SHALL hold their value until the next successful read completion for that port; writes and timeouts SHALL leave rdata unchanged.
REQ-015 The non-owner's done/err SHALL remain 0 throughout another port's access.
REQ-016 busy SHALL equal (state != IDLE).

Reset
REQ-017 reset=1 SHALL force, on the next edge:
- state IDLE, counter 0
- all done/err/mem_en/mem_we/busy = 0
- mem_addr/mem_wdata/rdata = 0
- owner = 0, last_owner = 1
REQ-018 reset asserted during ACCESS SHALL abort the access with no done/err pulse; mem_en SHALL be 0 from the next cycle.

Verification
REQ-019 CPU read: cpu_req=1, we=0, addr=0x40; mem_ready after 2 cycles with mem_rdata=0xDEADBEEF -> mem_en high 3 cycles, mem_addr=0x40, cpu_done 1 cycle, cpu_rdata=0xDEADBEEF, dma_done=0.
REQ-020 Tie after reset: both req=1 continuously -> grants alternate CPU, DMA, CPU, DMA; owner toggles 0,1,0,1.
REQ-021 DMA write: dma_we=1, addr=0x100, wdata=0x12345678, mem_ready immediately -> mem_we=1, mem_wdata=0x12345678, dma_done pulse, dma_rdata unchanged.
REQ-022 Timeout: cpu_req=1, mem_ready held 0 -> mem_en high 16 cycles, then cpu_err=1 for one cycle, cpu_done=0, state IDLE; repeat with mem_ready on the 16th cycle -> cpu_done instead.
REQ-023 Reset mid-access: assert reset on the 2nd ACCESS cycle -> mem_en=0 next cycle, no done/err, owner=0, busy=0.
REQ-024 Request drop: CPU drops req during ACCESS and changes addr -> mem_addr unchanged, cpu_done still pulses.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, memory and status signals of the two-port memory arbiter
// master: the arbiter's view (takes requests and memory responses, drives memory and completions)
// slave:  the environment's view (requesters and memory model)
interface mem_arbiter_if;
    logic        cpu_req, cpu_we, cpu_done, cpu_err;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_done, dma_err;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_en, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy, owner;
    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata, mem_ready,
        output cpu_rdata, cpu_done, cpu_err,
        output dma_rdata, dma_done, dma_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, owner
    );
    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata, mem_ready,
        input  cpu_rdata, cpu_done, cpu_err,
        input  dma_rdata, dma_done, dma_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin CPU/DMA arbiter onto one memory port with a 16-cycle access timeout
// clk, reset: single clock, synchronous active-high reset
// bus: cpu_*/dma_* requester handshakes, mem_* memory strobe/response, busy/owner status
module mem_arbiter (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        owner_q, last_q, we_q, mem_en_q;
    logic [31:0] addr_q, wdata_q, cpu_rdata_q, dma_rdata_q;
    logic        cpu_done_q, cpu_err_q, dma_done_q, dma_err_q;
    logic        win_d, fin_d;
    // a tie goes to whoever did not own the previous access
    assign win_d = (bus.cpu_req && bus.dma_req) ? !last_q : bus.dma_req;
    // ready wins over the timeout when both land in the same cycle
    assign fin_d = bus.mem_ready || cnt_q == 4'd15;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            cpu_err_q   <= 1'b0;
            dma_done_q  <= 1'b0;
            dma_err_q   <= 1'b0;
        end else begin
            cpu_done_q <= 1'b0;
            cpu_err_q  <= 1'b0;
            dma_done_q <= 1'b0;
            dma_err_q  <= 1'b0;
            case (state_q)
                IDLE: if (bus.cpu_req || bus.dma_req) begin
                    owner_q  <= win_d;
                    we_q     <= win_d ? bus.dma_we : bus.cpu_we;
                    addr_q   <= win_d ? bus.dma_addr : bus.cpu_addr;
                    wdata_q  <= win_d ? bus.dma_wdata : bus.cpu_wdata;
                    cnt_q    <= '0;
                    mem_en_q <= 1'b1;
                    state_q  <= ACCESS;
                end
                ACCESS: if (fin_d) begin
                    mem_en_q   <= 1'b0;
                    state_q    <= DONE;
                    cpu_done_q <= !owner_q && bus.mem_ready;
                    cpu_err_q  <= !owner_q && !bus.mem_ready;
                    dma_done_q <= owner_q && bus.mem_ready;
                    dma_err_q  <= owner_q && !bus.mem_ready;
                    if (bus.mem_ready && !we_q && !owner_q) cpu_rdata_q <= bus.mem_rdata;
                    if (bus.mem_ready && !we_q && owner_q) dma_rdata_q <= bus.mem_rdata;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
                DONE: begin
                    last_q  <= owner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_en_q && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.cpu_err   = cpu_err_q;
    assign bus.dma_done  = dma_done_q;
    assign bus.dma_err   = dma_err_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transaction-level checks of mem_arbiter
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic        last;
    logic [31:0] exp_rd [2];
    logic        own;
    mem_arbiter_if bus ();
    mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rnd_ports;
        bus.cpu_we = 1'($urandom);
        bus.cpu_addr = $urandom;
        bus.cpu_wdata = $urandom;
        bus.dma_we = 1'($urandom);
        bus.dma_addr = $urandom;
        bus.dma_wdata = $urandom;
    endtask

    // One full service from IDLE: lat = ready-low cycles before ready, >15 means never ready.
    task automatic txn(input bit creq, input bit dreq, input bit hold, input int lat,
                       input logic [31:0] rd, output logic own_o);
        logic        w, we;
        logic [31:0] a, wd;
        int          en;
        bit          to;
        en = 0;
        w  = (creq && dreq) ? !last : dreq;
        we = w ? bus.dma_we : bus.cpu_we;
        a  = w ? bus.dma_addr : bus.cpu_addr;
        wd = w ? bus.dma_wdata : bus.cpu_wdata;
        to = lat > 15;
        bus.cpu_req = creq;
        bus.dma_req = dreq;
        bus.mem_ready = 1'b0;
        chk("idle_busy", bus.busy, 0);
        tick;
        own_o = bus.owner;
        chk("grant_owner", bus.owner, w);
        chk("grant_addr", bus.mem_addr, a);
        chk("grant_we", bus.mem_we, we);
        chk("grant_wdata", bus.mem_wdata, wd);
        chk("access_busy", bus.busy, 1);
        if (!hold) begin
            bus.cpu_req = 1'b0;
            bus.dma_req = 1'b0;
            rnd_ports;
        end
        for (int k = 0; k < 16; k++) begin
            if (bus.mem_en === 1'b1) en++;
            bus.mem_ready = (k == lat);
            bus.mem_rdata = rd;
            tick;
            if (k == lat || k == 15) break;
            chk("hold_addr", bus.mem_addr, a);
            chk("hold_wdata", bus.mem_wdata, wd);
            chk("no_early_done", {bus.cpu_done, bus.cpu_err, bus.dma_done, bus.dma_err}, 0);
        end
        bus.mem_ready = 1'b0;
        if (!to && !we) exp_rd[w] = rd;
        chk("done_mem_en", bus.mem_en, 0);
        chk("en_cycles", en, to ? 16 : lat + 1);
        chk("cpu_done", bus.cpu_done, !w && !to);
        chk("cpu_err", bus.cpu_err, !w && to);
        chk("dma_done", bus.dma_done, w && !to);
        chk("dma_err", bus.dma_err, w && to);
        chk("cpu_rdata", bus.cpu_rdata, exp_rd[0]);
        chk("dma_rdata", bus.dma_rdata, exp_rd[1]);
        chk("done_busy", bus.busy, 1);
        last = w;
        tick;
        chk("back_idle", bus.busy, 0);
        chk("pulse_end", {bus.cpu_done, bus.cpu_err, bus.dma_done, bus.dma_err}, 0);
    endtask

    initial begin
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        rnd_ports;
        last = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        tick;
        tick;
        chk("rst_busy", bus.busy, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_owner", bus.owner, 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        chk("rst_dma_rdata", bus.dma_rdata, 0);
        chk("rst_pulses", {bus.cpu_done, bus.cpu_err, bus.dma_done, bus.dma_err}, 0);
        reset = 1'b0;
        tick;
        chk("idle_stay", {bus.busy, bus.mem_en}, 0);
        for (int i = 0; i < 4; i++) begin
            txn(1'b1, 1'b1, 1'b1, $urandom_range(0, 3), $urandom, own);
            chk("tie_seq", own, i % 2);
        end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 32'h40;
        txn(1'b1, 1'b0, 1'b0, 2, 32'hDEADBEEF, own);
        chk("cpu_read_data", bus.cpu_rdata, 32'hDEADBEEF);
        bus.dma_we = 1'b1;
        bus.dma_addr = 32'h100;
        bus.dma_wdata = 32'h12345678;
        txn(1'b0, 1'b1, 1'b0, 0, $urandom, own);
        txn(1'b1, 1'b0, 1'b0, 16, $urandom, own);
        txn(1'b1, 1'b0, 1'b0, 15, $urandom, own);
        bus.cpu_req = 1'b1;
        tick;
        bus.cpu_req = 1'b0;
        tick;
        chk("mid_mem_en", bus.mem_en, 1);
        reset = 1'b1;
        tick;
        chk("abort_mem_en", bus.mem_en, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_owner", bus.owner, 0);
        chk("abort_pulses", {bus.cpu_done, bus.cpu_err, bus.dma_done, bus.dma_err}, 0);
        reset = 1'b0;
        last = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        tick;
        chk("abort_quiet", {bus.cpu_done, bus.cpu_err, bus.dma_done, bus.dma_err, bus.busy}, 0);
        for (int i = 0; i < 40; i++) begin
            bit c, d;
            int lat;
            rnd_ports;
            c = 1'($urandom);
            d = 1'($urandom);
            if (!c && !d) c = 1'b1;
            lat = ($urandom_range(0, 4) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 4);
            txn(c, d, 1'($urandom), lat, $urandom, own);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
